cnt_gate_ctrl: RTL and testbench

- Sequencer for a bank of NUM_CH pulse counters. Each counter is a debounced edge counter with enable and async clear inputs.
- Per measurement: clears the selected counters, opens a gate window of programmable length, then waits for the counters' input filters to drain.
- Then snapshots all counter values and streams the selected channels out over a valid/ready read port.
- Sits between the host/register interface and the counter instances; these are the only drivers of the counters' enable and clear inputs.

---
 rtl/cnt_gate_ctrl_if.sv | 19 +
 rtl/cnt_gate_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_cnt_gate_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_gate_ctrl_if.sv
// Read-out port of cnt_gate_ctrl: one captured counter value per beat.
// Handshake: a beat moves on every rising clock edge where rd_valid and
// rd_ready are both high. While rd_valid is high and rd_ready is low,
// rd_ch and rd_data hold their values. The master never withdraws
// rd_valid without a handshake, except on abort or reset.
interface cnt_gate_ctrl_if #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                 rd_valid;
  logic [CH_W-1:0]      rd_ch;
  logic [CNT_WIDTH-1:0] rd_data;
  logic                 rd_ready;

  modport master (output rd_valid, output rd_ch, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_ch, input rd_data, output rd_ready);
endinterface

// File: rtl/cnt_gate_ctrl.sv
// cnt_gate_ctrl: measurement sequencer for a bank of gated pulse counters.
// Sequence per measurement: CLEAR (1 cycle) -> GATE (gate_len cycles) ->
// SETTLE (SETTLE_CYC cycles, lets the counter input filters drain) ->
// CAPTURE (snapshot all channels) -> READOUT (masked channels, ascending).
// Optional build macro CNT_GATE_CTRL_AUTO_RESTART_EN: after the last read
// beat the sequencer loops straight back to CLEAR with the same settings
// instead of returning to IDLE.
// o_dbg_state exposes the FSM state encoding for observation.
module cnt_gate_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 8,
  parameter int GATE_WIDTH = 16,
  parameter int SETTLE_CYC = 18
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic [GATE_WIDTH-1:0]       i_gate_len,
  input  logic [NUM_CH-1:0]           i_ch_mask,
  input  logic [NUM_CH*CNT_WIDTH-1:0] i_cnt_val,
  output logic [NUM_CH-1:0]           o_cnt_rst,
  output logic [NUM_CH-1:0]           o_cnt_en,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err,
  output logic [2:0]                  o_dbg_state,
  cnt_gate_ctrl_if.master             rd
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_GATE    = 3'd2,
    S_SETTLE  = 3'd3,
    S_CAPTURE = 3'd4,
    S_READOUT = 3'd5
  } state_t;

  state_t                      r_state;
  logic [GATE_WIDTH-1:0]       r_len;
  logic [NUM_CH-1:0]           r_mask;
  logic [GATE_WIDTH-1:0]       r_gate_cnt;
  logic [SET_W-1:0]            r_settle_cnt;
  logic [NUM_CH*CNT_WIDTH-1:0] r_shadow;
  logic [NUM_CH-1:0]           r_cnt_rst;
  logic [NUM_CH-1:0]           r_cnt_en;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_err;
  logic                        r_rd_valid;
  logic [CH_W-1:0]             r_rd_ch;
  logic [CNT_WIDTH-1:0]        r_rd_data;

  logic [CH_W-1:0]             w_first_ch;
  logic [CH_W-1:0]             w_next_ch;
  logic                        w_has_next;
  logic [CNT_WIDTH-1:0]        w_first_data;
  logic [CNT_WIDTH-1:0]        w_next_data;

  // Lowest selected channel, and the next selected channel above the one
  // currently presented (descending scan so the lowest match wins).
  always_comb begin
    w_first_ch = '0;
    w_next_ch  = '0;
    w_has_next = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_first_ch = CH_W'(i);
        if (i > int'(r_rd_ch)) begin
          w_next_ch  = CH_W'(i);
          w_has_next = 1'b1;
        end
      end
    end
  end

  // The first beat is taken from the live counter bus in the capture cycle,
  // which is the same value being written into the shadow registers.
  assign w_first_data = i_cnt_val[int'(w_first_ch)*CNT_WIDTH +: CNT_WIDTH];
  assign w_next_data  = r_shadow[int'(w_next_ch)*CNT_WIDTH +: CNT_WIDTH];

  // Measurement FSM with all outputs registered; abort overrides every state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_mask       <= '0;
      r_gate_cnt   <= '0;
      r_settle_cnt <= '0;
      r_shadow     <= '0;
      r_cnt_rst    <= '0;
      r_cnt_en     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_ch      <= '0;
      r_rd_data    <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (i_abort && (r_state != S_IDLE)) begin
        r_state    <= S_IDLE;
        r_cnt_rst  <= '0;
        r_cnt_en   <= '0;
        r_rd_valid <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              if ((i_gate_len == '0) || (i_ch_mask == '0)) begin
                r_err <= 1'b1;
              end else begin
                r_len     <= i_gate_len;
                r_mask    <= i_ch_mask;
                r_cnt_rst <= i_ch_mask;
                r_busy    <= 1'b1;
                r_state   <= S_CLEAR;
              end
            end
          end
          S_CLEAR: begin
            r_cnt_rst  <= '0;
            r_cnt_en   <= r_mask;
            r_gate_cnt <= r_len;
            r_state    <= S_GATE;
          end
          S_GATE: begin
            // Counter holds the remaining enable cycles including this one,
            // so a full-scale length never needs a wider counter.
            if (r_gate_cnt == GATE_WIDTH'(1)) begin
              r_cnt_en     <= '0;
              r_settle_cnt <= SET_W'(SETTLE_CYC);
              r_state      <= S_SETTLE;
            end else begin
              r_gate_cnt <= r_gate_cnt - GATE_WIDTH'(1);
            end
          end
          S_SETTLE: begin
            if (r_settle_cnt == SET_W'(1)) begin
              r_state <= S_CAPTURE;
            end else begin
              r_settle_cnt <= r_settle_cnt - SET_W'(1);
            end
          end
          S_CAPTURE: begin
            r_shadow   <= i_cnt_val;
            r_rd_valid <= 1'b1;
            r_rd_ch    <= w_first_ch;
            r_rd_data  <= w_first_data;
            r_state    <= S_READOUT;
          end
          S_READOUT: begin
            if (rd.rd_ready) begin
              if (w_has_next) begin
                r_rd_ch   <= w_next_ch;
                r_rd_data <= w_next_data;
              end else begin
                r_rd_valid <= 1'b0;
                r_done     <= 1'b1;
`ifdef CNT_GATE_CTRL_AUTO_RESTART_EN
                r_cnt_rst  <= r_mask;
                r_state    <= S_CLEAR;
`else
                r_busy     <= 1'b0;
                r_state    <= S_IDLE;
`endif
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_cnt_rst   = r_cnt_rst;
  assign o_cnt_en    = r_cnt_en;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_dbg_state = r_state;
  assign rd.rd_valid = r_rd_valid;
  assign rd.rd_ch    = r_rd_ch;
  assign rd.rd_data  = r_rd_data;

endmodule

// File: tb/tb_cnt_gate_ctrl.sv
// Directed bench for cnt_gate_ctrl. A behavioural counter stub stands in
// for the counter bank: channel c adds (c+1)/2 counts per enabled cycle,
// so captured values differ per channel and wrap at 8 bits.
module tb_cnt_gate_ctrl;
  localparam int NUM_CH     = 4;
  localparam int CNT_WIDTH  = 8;
  localparam int GATE_WIDTH = 16;
  localparam int SETTLE_CYC = 18;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_GATE    = 3'd2;
  localparam logic [2:0] ST_SETTLE  = 3'd3;
  localparam logic [2:0] ST_READOUT = 3'd5;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst_n = 1'b0;
  logic                        start = 1'b0;
  logic                        abort = 1'b0;
  logic                        ready = 1'b0;
  logic [GATE_WIDTH-1:0]       gate_len = '0;
  logic [NUM_CH-1:0]           ch_mask = '0;
  logic [NUM_CH*CNT_WIDTH-1:0] cnt_val;
  logic [NUM_CH-1:0]           cnt_rst;
  logic [NUM_CH-1:0]           cnt_en;
  logic                        busy;
  logic                        done;
  logic                        err;
  logic [2:0]                  dbg_state;

  int checks   = 0;
  int failures = 0;

  cnt_gate_ctrl_if #(.NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH)) rd_if ();
  assign rd_if.rd_ready = ready;

  cnt_gate_ctrl #(
    .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH),
    .GATE_WIDTH(GATE_WIDTH), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_gate_len(gate_len), .i_ch_mask(ch_mask), .i_cnt_val(cnt_val),
    .o_cnt_rst(cnt_rst), .o_cnt_en(cnt_en), .o_busy(busy),
    .o_done(done), .o_err(err), .o_dbg_state(dbg_state), .rd(rd_if)
  );

  // ---------------- counter stub and activity monitor ----------------
  int en_cyc    [NUM_CH];
  int en_total  [NUM_CH];
  int rst_total [NUM_CH];

  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (cnt_rst[c]) en_cyc[c] <= 0;
      else if (cnt_en[c]) en_cyc[c] <= en_cyc[c] + 1;
      if (cnt_en[c]) en_total[c] <= en_total[c] + 1;
      if (cnt_rst[c]) rst_total[c] <= rst_total[c] + 1;
    end
  end

  always_comb begin
    cnt_val = '0;
    for (int c = 0; c < NUM_CH; c++)
      cnt_val[c*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'((en_cyc[c] * (c + 1)) >> 1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (rd_if.rd_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic launch(input logic [GATE_WIDTH-1:0] len, input logic [NUM_CH-1:0] mask);
    gate_len = len;
    ch_mask  = mask;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  logic [CNT_WIDTH-1:0] exp_q[$];
  int en_base  [NUM_CH];
  int rst_base [NUM_CH];

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    logic [CNT_WIDTH-1:0] exp_data;
    logic saw_done;

    // Reset with the consumer ready line toggling.
    rst_n = 1'b0;
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("rst_outputs", {cnt_rst, cnt_en, busy, done, err, rd_if.rd_valid,
                        rd_if.rd_ch, rd_if.rd_data}, 32'd0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    tick();
    chk("idle_after_rst", {busy, rd_if.rd_valid, done}, 32'd0);

    // Basic measurement: ch0/ch2, gate 10.
    for (int c = 0; c < NUM_CH; c++) begin
      en_base[c]  = en_total[c];
      rst_base[c] = rst_total[c];
    end
    launch(16'd10, 4'b0101);
    chk("basic_clear_rst", cnt_rst, 4'b0101);
    chk("basic_clear_en", cnt_en, 4'b0000);
    chk("basic_clear_busy", busy, 1'b1);
    chk("basic_clear_state", dbg_state, ST_CLEAR);
    tick();
    chk("basic_gate_first_en", cnt_en, 4'b0101);
    chk("basic_gate_first_rst", cnt_rst, 4'b0000);
    repeat (9) tick();
    chk("basic_gate_last_en", cnt_en, 4'b0101);
    tick();
    chk("basic_gate_off_en", cnt_en, 4'b0000);
    chk("basic_settle_state", dbg_state, ST_SETTLE);
    wait_valid(n);
    chk("basic_valid_latency", n, 19);
    chk("basic_beat0_ch", rd_if.rd_ch, 2'd0);
    chk("basic_beat0_data", rd_if.rd_data, 8'd5);
    ready = 1'b1;
    tick();
    chk("basic_beat1_valid", rd_if.rd_valid, 1'b1);
    chk("basic_beat1_ch", rd_if.rd_ch, 2'd2);
    chk("basic_beat1_data", rd_if.rd_data, 8'd15);
    tick();
    ready = 1'b0;
    chk("basic_done", done, 1'b1);
    chk("basic_end_valid", rd_if.rd_valid, 1'b0);
    chk("basic_end_busy", busy, 1'b0);
    chk("basic_end_state", dbg_state, ST_IDLE);
    chk("basic_en_ch0", en_total[0] - en_base[0], 10);
    chk("basic_en_ch1", en_total[1] - en_base[1], 0);
    chk("basic_en_ch2", en_total[2] - en_base[2], 10);
    chk("basic_en_ch3", en_total[3] - en_base[3], 0);
    chk("basic_rst_ch0", rst_total[0] - rst_base[0], 1);
    chk("basic_rst_ch1", rst_total[1] - rst_base[1], 0);

    // Start in the done cycle is accepted: backpressure run, all channels, gate 4.
    launch(16'd4, 4'b1111);
    chk("restart_in_done_rst", cnt_rst, 4'b1111);
    chk("restart_in_done_busy", busy, 1'b1);
    chk("restart_done_cleared", done, 1'b0);
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd4);
    exp_q.push_back(8'd6);
    exp_q.push_back(8'd8);
    wait_valid(n);
    chk("bp_valid_latency", n, 24);
    for (int b = 0; b < NUM_CH; b++) begin
      exp_data = exp_q.pop_front();
      for (int j = 0; j < 3; j++) begin
        chk("bp_stall_valid", rd_if.rd_valid, 1'b1);
        chk("bp_stall_ch", rd_if.rd_ch, b[1:0]);
        chk("bp_stall_data", rd_if.rd_data, exp_data);
        if (b == 1 && j == 0) begin
          gate_len = '0;
          start    = 1'b1;
        end
        tick();
        if (b == 1 && j == 0) begin
          start = 1'b0;
          chk("busy_start_no_err", err, 1'b0);
          chk("busy_start_state", dbg_state, ST_READOUT);
        end
      end
      chk("bp_hs_ch", rd_if.rd_ch, b[1:0]);
      ready = 1'b1;
      tick();
      ready = 1'b0;
    end
    chk("bp_queue_empty", exp_q.size(), 0);
    chk("bp_end_valid", rd_if.rd_valid, 1'b0);
    chk("bp_done", done, 1'b1);
    tick();
    chk("bp_done_one_cycle", done, 1'b0);
    chk("bp_idle_busy", busy, 1'b0);

    // Rejected starts.
    launch(16'd0, 4'b1111);
    chk("rej_len_err", err, 1'b1);
    chk("rej_len_ctrl", {busy, cnt_en, cnt_rst}, 32'd0);
    chk("rej_len_state", dbg_state, ST_IDLE);
    tick();
    chk("rej_len_err_pulse", err, 1'b0);
    launch(16'd5, 4'b0000);
    chk("rej_mask_err", err, 1'b1);
    chk("rej_mask_ctrl", {busy, cnt_en, cnt_rst}, 32'd0);
    tick();
    chk("rej_mask_err_pulse", err, 1'b0);

    // Abort on the 5th gate cycle.
    launch(16'd10, 4'b0011);
    tick();
    repeat (4) tick();
    chk("abort_gate_en_before", cnt_en, 4'b0011);
    chk("abort_gate_state_before", dbg_state, ST_GATE);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_gate_state", dbg_state, ST_IDLE);
    chk("abort_gate_ctrl", {busy, cnt_en, cnt_rst, rd_if.rd_valid}, 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      saw_done = saw_done | done;
      tick();
    end
    chk("abort_gate_no_done", saw_done, 1'b0);

    // Abort on the first readout cycle with the consumer stalled.
    launch(16'd2, 4'b0100);
    wait_valid(n);
    chk("abort_rd_latency", n, 22);
    chk("abort_rd_ch", rd_if.rd_ch, 2'd2);
    chk("abort_rd_data", rd_if.rd_data, 8'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_rd_valid", rd_if.rd_valid, 1'b0);
    chk("abort_rd_done", done, 1'b0);
    chk("abort_rd_state", dbg_state, ST_IDLE);
    tick();
    chk("abort_rd_no_late_done", done, 1'b0);

    // A fresh measurement after abort completes normally.
    launch(16'd3, 4'b0100);
    wait_valid(n);
    chk("post_abort_latency", n, 23);
    chk("post_abort_ch", rd_if.rd_ch, 2'd2);
    chk("post_abort_data", rd_if.rd_data, 8'd4);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("post_abort_done", done, 1'b1);
    chk("post_abort_valid", rd_if.rd_valid, 1'b0);

    // Full-scale gate length on channel 0.
    launch(16'hFFFF, 4'b0001);
    tick();
    n = 0;
    while (cnt_en[0] === 1'b1 && n < 70000) begin
      n++;
      tick();
    end
    chk("max_gate_en_cycles", n, 65535);
    wait_valid(n);
    chk("max_gate_latency", n, 19);
    chk("max_gate_ch", rd_if.rd_ch, 2'd0);
    chk("max_gate_data_wrap", rd_if.rd_data, 8'hFF);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("max_gate_done", done, 1'b1);
`ifdef CNT_GATE_CTRL_AUTO_RESTART_EN
    chk("auto_restart_rst", cnt_rst, 4'b0001);
    chk("auto_restart_busy", busy, 1'b1);
    chk("auto_restart_state", dbg_state, ST_CLEAR);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("auto_restart_abort", {busy, cnt_en, cnt_rst}, 32'd0);
`else
    chk("max_gate_end_busy", busy, 1'b0);
    chk("max_gate_end_rst", cnt_rst, 4'b0000);
    chk("max_gate_end_state", dbg_state, ST_IDLE);
`endif

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
